// File: rtl/fp32_div_if.sv
// Operand/result handshake bundle for the sequential binary32 divider.
interface fp32_div_if;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] out;
  logic        busy;
  logic        done;

  modport master (output start, output in1, output in2, input out, input busy, input done);
  modport slave  (input start, input in1, input in2, output out, output busy, output done);
endinterface

// File: rtl/fp32_div_seq.sv
// Iterative binary32 divider: restoring mantissa division, one quotient bit per clock,
// flush-to-zero on denormals, truncating rounding.
module fp32_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  fp32_div_if.slave   bus
);
  localparam int unsigned EXPW = 8;
  localparam int unsigned FRW  = 23;
  localparam int unsigned MW   = 24;
  localparam int unsigned RW   = 26;
  localparam int unsigned QW   = 25;
  localparam int unsigned EW   = 10;
  localparam int unsigned CW   = 5;
  localparam logic [CW-1:0] LAST_BIT = CW'(QW - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        count, count_n;
  logic [RW-1:0]        rem, rem_n;
  logic [QW-1:0]        quo, quo_n;
  logic [MW-1:0]        mb, mb_n;
  logic signed [EW-1:0] exp_q, exp_n;
  logic                 sign_q, sign_n;
  logic [31:0]          out_q, out_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;

  // Operand classification (denormals count as zero)
  logic [EXPW-1:0] e1, e2;
  logic [FRW-1:0]  f1, f2;
  logic            sign_in, zero1, zero2, inf1, inf2, nan1, nan2;
  logic            nan_case, inf_case, zero_case;

  assign e1        = bus.in1[30:23];
  assign e2        = bus.in2[30:23];
  assign f1        = bus.in1[22:0];
  assign f2        = bus.in2[22:0];
  assign sign_in   = bus.in1[31] ^ bus.in2[31];
  assign zero1     = (e1 == '0);
  assign zero2     = (e2 == '0);
  assign inf1      = (e1 == '1) && (f1 == '0);
  assign inf2      = (e2 == '1) && (f2 == '0);
  assign nan1      = (e1 == '1) && (f1 != '0);
  assign nan2      = (e2 == '1) && (f2 != '0);
  assign nan_case  = nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2);
  assign inf_case  = inf1 || zero2;
  assign zero_case = zero1 || inf2;

  // Datapath helpers for the DIV and NORM steps
  logic                 q_bit;
  logic [RW-1:0]        rem_diff, rem_keep;
  logic signed [EW-1:0] norm_exp;
  logic [FRW-1:0]       norm_frac;

  assign q_bit     = (rem >= {2'b00, mb});
  assign rem_diff  = rem - {2'b00, mb};
  assign rem_keep  = q_bit ? rem_diff : rem;
  assign norm_exp  = quo[QW-1] ? exp_q : (exp_q - 10'sd1);
  assign norm_frac = quo[QW-1] ? quo[23:1] : quo[22:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      mb     <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
      out_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      rem    <= rem_n;
      quo    <= quo_n;
      mb     <= mb_n;
      exp_q  <= exp_n;
      sign_q <= sign_n;
      out_q  <= out_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    rem_n   = rem;
    quo_n   = quo;
    mb_n    = mb;
    exp_n   = exp_q;
    sign_n  = sign_q;
    out_n   = out_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (nan_case) begin
            out_n  = QNAN;
            done_n = 1'b1;
          end else if (inf_case) begin
            out_n  = {sign_in, 8'hFF, 23'd0};
            done_n = 1'b1;
          end else if (zero_case) begin
            out_n  = {sign_in, 31'd0};
            done_n = 1'b1;
          end else begin
            rem_n   = {2'b01, f1};
            mb_n    = {1'b1, f2};
            exp_n   = $signed({2'b00, e1} - {2'b00, e2} + 10'd127);
            sign_n  = sign_in;
            quo_n   = '0;
            count_n = '0;
            busy_n  = 1'b1;
            state_n = DIV;
          end
        end
      end
      DIV: begin
        quo_n   = {quo[QW-2:0], q_bit};
        rem_n   = rem_keep << 1;
        count_n = count + CW'(1);
        if (count == LAST_BIT) state_n = NORM;
      end
      NORM: begin
        if (norm_exp >= 10'sd255)   out_n = {sign_q, 8'hFF, 23'd0};
        else if (norm_exp <= 10'sd0) out_n = {sign_q, 31'd0};
        else                          out_n = {sign_q, norm_exp[EXPW-1:0], norm_frac};
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_fp32_div_seq.sv
// Self-checking bench for fp32_div_seq: directed cases, handshake scenarios and
// randomized operands checked against an integer-arithmetic reference.
module tb_fp32_div_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fp32_div_if bus ();
  fp32_div_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference: exact integer quotient of the mantissas, truncated, then packed
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          output bit special);
    int     ea, eb, e;
    longint ma, mb, q, frac;
    bit     s, za, zb, ia, ib, na, nb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    special = 1'b1;
    if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC0_0000;
    if (ia || zb) return {s, 8'hFF, 23'd0};
    if (za || ib) return {s, 31'd0};
    special = 1'b0;
    ma = longint'(a[22:0]) + 64'd8388608;
    mb = longint'(b[22:0]) + 64'd8388608;
    q  = (ma * 64'd16777216) / mb;
    e  = ea - eb + 127;
    if (q >= 64'd16777216) frac = (q / 2) % 64'd8388608;
    else begin
      frac = q % 64'd8388608;
      e    = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, 8'(e), 23'(frac)};
  endfunction

  // Issue one operation; reports result, edges from acceptance to done, busy behaviour
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                       output int lat, output bit busy_hi, output bit busy_end);
    @(negedge clk);
    bus.in1   = a;
    bus.in2   = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat     = 0;
    busy_hi = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_hi = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res      = bus.out;
    busy_end = bus.busy;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.out !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h want 00000000", bus.out); end
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [10] = '{32'h4080_0000, 32'h40A8_0000, 32'hC000_0000, 32'h3F80_0000,
                             32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000,
                             32'h7F00_0000, 32'h0080_0000};
    logic [31:0] tb_ [10] = '{32'h4000_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4040_0000,
                             32'h0000_0000, 32'h0000_0000, 32'hC000_0000, 32'h3F80_0000,
                             32'h3E80_0000, 32'h4000_0000};
    logic [31:0] tq [10] = '{32'h4000_0000, 32'h4028_0000, 32'hC080_0000, 32'h3EAA_AAAA,
                             32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h7FC0_0000,
                             32'h7F80_0000, 32'h0000_0000};
    int          tl [10] = '{26, 26, 26, 26, 0, 0, 0, 0, 26, 26};
    logic [31:0] res;
    int          lat;
    bit          bh, be;
    for (int i = 0; i < 10; i++) begin
      issue(ta[i], tb_[i], res, lat, bh, be);
      n_vec++;
      if (res !== tq[i]) begin
        n_err++; $display("FAIL directed_out[%0d]: %h/%h got %h want %h", i, ta[i], tb_[i], res, tq[i]);
      end
      n_vec++;
      if (lat != tl[i]) begin
        n_err++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, tl[i]);
      end
      n_vec++;
      if (tl[i] == 0 ? (be !== 1'b0) : (bh !== 1'b1 || be !== 1'b0)) begin
        n_err++; $display("FAIL directed_busy[%0d]: busy_high=%b busy_at_done=%b", i, bh, be);
      end
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [7:0] e;
    int         sel;
    sel = int'($urandom_range(0, 19));
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else if (sel == 2) e = 8'($urandom_range(1, 254));
    else               e = 8'($urandom_range(70, 184));
    return {1'($urandom), e, (sel == 1 && $urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
  endfunction

  task automatic test_random();
    logic [31:0] a, b, res, want;
    int          lat;
    bit          bh, be, sp;
    for (int i = 0; i < 80; i++) begin
      a    = rand_operand();
      b    = rand_operand();
      want = ref_div(a, b, sp);
      issue(a, b, res, lat, bh, be);
      n_vec++;
      if (res !== want) begin
        n_err++; $display("FAIL random_out: %h/%h got %h want %h", a, b, res, want);
      end
      n_vec++;
      if (lat != (sp ? 0 : 26)) begin
        n_err++; $display("FAIL random_latency: %h/%h got %0d want %0d", a, b, lat, sp ? 0 : 26);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] want;
    int          lat;
    bit          sp;
    want = ref_div(32'h3F80_0000, 32'h4040_0000, sp);
    @(negedge clk);
    bus.in1   = 32'h3F80_0000;
    bus.in2   = 32'h4040_0000;
    bus.start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      bus.start = (lat == 5);
      if (lat == 5) begin
        bus.in1 = 32'h4080_0000;
        bus.in2 = 32'h4000_0000;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    n_vec++;
    if (bus.out !== want) begin n_err++; $display("FAIL ignored_start_out: got %h want %h", bus.out, want); end
    n_vec++;
    if (lat != 26) begin n_err++; $display("FAIL ignored_start_latency: got %0d want 26", lat); end
    repeat (30) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.done !== 1'b0) begin n_err++; $display("FAIL ignored_start_extra_done: got %b want 0", bus.done); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, want1, want2;
    int          lat, gap;
    bit          bh, be, sp;
    want1 = ref_div(32'h40A8_0000, 32'h4000_0000, sp);
    want2 = ref_div(32'hC000_0000, 32'h3F00_0000, sp);
    issue(32'h40A8_0000, 32'h4000_0000, res, lat, bh, be);
    n_vec++;
    if (res !== want1) begin n_err++; $display("FAIL b2b_first: got %h want %h", res, want1); end
    bus.in1   = 32'hC000_0000;
    bus.in2   = 32'h3F00_0000;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    gap = 1;
    while (bus.done !== 1'b1 && gap < 60) begin
      @(posedge clk); #1;
      gap++;
    end
    n_vec++;
    if (gap != 27) begin n_err++; $display("FAIL b2b_gap: got %0d want 27", gap); end
    n_vec++;
    if (bus.out !== want2) begin n_err++; $display("FAIL b2b_second: got %h want %h", bus.out, want2); end
  endtask

  task automatic test_reset_abort();
    bit seen_done;
    @(negedge clk);
    bus.in1   = 32'h4080_0000;
    bus.in2   = 32'h4000_0000;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out !== 32'h0) begin n_err++; $display("FAIL abort_out: got %h want 00000000", bus.out); end
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    rst_n     = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done) begin n_err++; $display("FAIL abort_no_done: activity seen after abort"); end
    n_vec++;
    if (bus.out !== 32'h0) begin n_err++; $display("FAIL abort_out_held: got %h want 00000000", bus.out); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
